// File: rtl/wb8_interconnect_pkg.sv
// Shared definitions for the 8-bit Wishbone interconnect: FSM states,
// fixed read values, the standard address-map constants and the region test.
package wb8_interconnect_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } wb8_state_t;

  // Read data presented in the cycle a bus error is signalled.
  localparam logic [7:0]  WB8_ERR_DATA  = 8'hFF;
  // Read data presented while no master owns the bus.
  localparam logic [7:0]  WB8_IDLE_DATA = 8'h00;

  // Standard address map.
  localparam logic [31:0] WB8_UART_BASE = 32'hFFFF_F800;
  localparam logic [31:0] WB8_UART_MASK = 32'hFFFF_FF00;

  // True when adr falls inside the region described by base/mask.
  function automatic logic wb8_region_hit(input logic [31:0] adr,
                                          input logic [31:0] base,
                                          input logic [31:0] mask);
    return ((adr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/wb8_interconnect_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at the master
// after the last owner and returns a one-hot grant (all-zero if no request).
module wb8_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_last,
  output logic [N-1:0]  o_grant
);

  logic w_found;

  // Pick the first requester at distance 1..N from the last owner.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int m = 0; m < N; m++) begin
        if (!w_found && i_req[m] && (((int'(i_last) + k) % N) == m)) begin
          o_grant[m] = 1'b1;
          w_found    = 1'b1;
        end else begin
          w_found    = w_found;
        end
      end
    end
  end

endmodule

// File: rtl/wb8_interconnect.sv
// Shared-bus Wishbone interconnect: N 8-bit masters arbitrated round-robin,
// address-decoded onto M slaves, with an ack-wait timeout raising ERR.
module wb8_interconnect
  import wb8_interconnect_pkg::*;
#(
  parameter int                    NMASTERS      = 2,
  parameter int                    NSLAVES       = 8,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE    = '0,
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK    = '0,
  parameter int                    DEFAULT_SLAVE = 0,
  parameter int                    TIMEOUT       = 255
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [NMASTERS-1:0]     M_CYC_I,
  input  logic [NMASTERS-1:0]     M_STB_I,
  input  logic [NMASTERS-1:0]     M_WE_I,
  input  logic [32*NMASTERS-1:0]  M_ADR_I,
  input  logic [8*NMASTERS-1:0]   M_DAT_I,
  output logic [7:0]              M_DAT_O,
  output logic [NMASTERS-1:0]     M_ACK_O,
  output logic [NMASTERS-1:0]     M_ERR_O,
  output logic [31:0]             S_ADR_O,
  output logic [7:0]              S_DAT_O,
  output logic                    S_WE_O,
  output logic [NSLAVES-1:0]      S_STB_O,
  input  logic [8*NSLAVES-1:0]    S_DAT_I,
  input  logic [NSLAVES-1:0]      S_ACK_I,
  output logic [NMASTERS-1:0]     O_grant
);

  localparam int             PW        = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int             SW        = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int             CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT);
  localparam logic           TO_EN     = (TIMEOUT > 0);

  wb8_state_t          r_state, w_state_nxt;
  logic [NMASTERS-1:0] r_grant, w_grant_nxt, w_arb_grant;
  logic [PW-1:0]       r_last, w_last_nxt, w_owner;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;

  logic                w_owned, w_cyc, w_stb, w_we, w_ack, w_err;
  logic [31:0]         w_adr;
  logic [7:0]          w_mdat, w_sdat;
  logic [SW-1:0]       w_sel;

  assign O_grant = r_grant;
  assign w_owned = (r_state == ST_OWNED);

  wb8_rr_arbiter #(.N(NMASTERS), .PW(PW)) u_arb (
    .i_req   (M_CYC_I),
    .i_last  (r_last),
    .o_grant (w_arb_grant)
  );

  // Mux the current owner's request signals (all zero when nobody owns).
  always_comb begin
    w_owner = '0;
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    w_we    = 1'b0;
    w_adr   = '0;
    w_mdat  = '0;
    for (int m = 0; m < NMASTERS; m++) begin
      if (r_grant[m]) begin
        w_owner = PW'(m);
        w_cyc   = M_CYC_I[m];
        w_stb   = M_STB_I[m];
        w_we    = M_WE_I[m];
        w_adr   = M_ADR_I[32*m +: 32];
        w_mdat  = M_DAT_I[8*m +: 8];
      end else begin
        w_owner = w_owner;
      end
    end
  end

  // Address decode: scan high to low so the lowest matching region wins.
  always_comb begin
    w_sel = SW'(DEFAULT_SLAVE);
    for (int s = NSLAVES - 1; s >= 0; s--) begin
      if (wb8_region_hit(w_adr, SLAVE_BASE[32*s +: 32], SLAVE_MASK[32*s +: 32])) begin
        w_sel = SW'(s);
      end else begin
        w_sel = w_sel;
      end
    end
  end

  // Return path from the selected slave.
  always_comb begin
    w_ack  = 1'b0;
    w_sdat = '0;
    for (int s = 0; s < NSLAVES; s++) begin
      if (w_sel == SW'(s)) begin
        w_ack  = S_ACK_I[s];
        w_sdat = S_DAT_I[8*s +: 8];
      end else begin
        w_ack  = w_ack;
      end
    end
  end

  // A timeout fires only when the slave is still silent; a late ACK wins.
  assign w_err = TO_EN && w_owned && w_stb && !w_ack && (r_cnt == CNT_LIMIT);

  // Drive the slave-side and master-side outputs with zero added latency.
  always_comb begin
    S_ADR_O = w_owned ? w_adr  : 32'h0000_0000;
    S_DAT_O = w_owned ? w_mdat : 8'h00;
    S_WE_O  = w_owned && w_we;
    S_STB_O = '0;
    M_ACK_O = '0;
    M_ERR_O = '0;
    for (int s = 0; s < NSLAVES; s++) begin
      S_STB_O[s] = w_owned && w_stb && !w_err && (w_sel == SW'(s));
    end
    for (int m = 0; m < NMASTERS; m++) begin
      M_ACK_O[m] = w_owned && r_grant[m] && w_ack;
      M_ERR_O[m] = r_grant[m] && w_err;
    end
    if (!w_owned) begin
      M_DAT_O = WB8_IDLE_DATA;
    end else if (w_err) begin
      M_DAT_O = WB8_ERR_DATA;
    end else begin
      M_DAT_O = w_sdat;
    end
  end

  // Next-state logic: arbitration, ownership release and the wait counter.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|M_CYC_I) begin
          w_state_nxt = ST_OWNED;
          w_grant_nxt = w_arb_grant;
        end else begin
          w_grant_nxt = '0;
        end
      end
      ST_OWNED: begin
        if (!w_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = w_owner;
        end else if (TO_EN && w_stb && !w_ack && !w_err) begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant, last-owner pointer and wait counter registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= PW'(NMASTERS - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb8_interconnect.sv
// Self-checking bench for wb8_interconnect: directed sequences, a decode
// vector table and randomized traffic checked against a behavioural model.
module tb_wb8_interconnect;
  import wb8_interconnect_pkg::*;

  localparam int NM = 2;
  localparam int NS = 8;
  localparam int TO = 4;

  localparam logic [NS*32-1:0] BASE = {32'h7000_0000, 32'h6000_0000, 32'h5000_0000,
                                       32'h4000_0000, 32'h2000_0000, WB8_UART_BASE,
                                       32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                       32'hF000_0000, 32'hF000_0000, WB8_UART_MASK,
                                       32'hFF00_0000, 32'hF000_0000};

  // Address map as the model sees it, written out slot by slot.
  logic [31:0] base_a [NS] = '{32'h1000_0000, 32'h2000_0000, 32'hFFFF_F800, 32'h2000_0000,
                               32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000};
  logic [31:0] mask_a [NS] = '{32'hF000_0000, 32'hFF00_0000, 32'hFFFF_FF00, 32'hF000_0000,
                               32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic              clk = 1'b0;
  logic              RST_I = 1'b1;
  logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
  logic [32*NM-1:0]  m_adr = '0;
  logic [8*NM-1:0]   m_dat = '0;
  logic [8*NS-1:0]   s_dat = '0;
  logic [NS-1:0]     s_ack = '0;
  logic [7:0]        M_DAT_O;
  logic [NM-1:0]     M_ACK_O, M_ERR_O, O_grant;
  logic [31:0]       S_ADR_O;
  logic [7:0]        S_DAT_O;
  logic              S_WE_O;
  logic [NS-1:0]     S_STB_O;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb8_interconnect #(
    .NMASTERS(NM), .NSLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .DEFAULT_SLAVE(7), .TIMEOUT(TO)
  ) dut (
    .CLK_I(clk), .RST_I(RST_I),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we), .M_ADR_I(m_adr), .M_DAT_I(m_dat),
    .M_DAT_O(M_DAT_O), .M_ACK_O(M_ACK_O), .M_ERR_O(M_ERR_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_WE_O(S_WE_O), .S_STB_O(S_STB_O),
    .S_DAT_I(s_dat), .S_ACK_I(s_ack), .O_grant(O_grant)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_owner = -1, m_last = NM - 1, m_wait = 0;
  int n_owner = -1, n_last = NM - 1, n_wait = 0;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
    return 7;
  endfunction

  function automatic int pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++)
      if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  typedef struct packed {
    logic [1:0]  grant;
    logic [7:0]  stb;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [7:0]  mdat;
    logic [31:0] adr;
    logic [7:0]  sdat;
    logic        we;
  } exp_t;

  task automatic model_step();
    exp_t e;
    int   sel;
    logic stb, ack, err;
    e = '0;
    if (RST_I) begin
      n_owner <= -1; n_last <= NM - 1; n_wait <= 0;
    end else if (m_owner < 0) begin
      n_owner <= pick(m_cyc, m_last); n_last <= m_last; n_wait <= 0;
    end else begin
      sel    = decode(m_adr[32*m_owner +: 32]);
      stb    = m_stb[m_owner];
      ack    = s_ack[sel];
      err    = stb && !ack && (m_wait == TO);
      e.grant = 2'(1 << m_owner);
      e.adr  = m_adr[32*m_owner +: 32];
      e.sdat = m_dat[8*m_owner +: 8];
      e.we   = m_we[m_owner];
      e.stb  = (stb && !err) ? 8'(1 << sel) : 8'h00;
      e.ack  = ack ? e.grant : 2'b00;
      e.err  = err ? e.grant : 2'b00;
      e.mdat = err ? 8'hFF : s_dat[8*sel +: 8];
      if (!m_cyc[m_owner]) begin
        n_owner <= -1; n_last <= m_owner; n_wait <= 0;
      end else begin
        n_owner <= m_owner; n_last <= m_last;
        n_wait  <= (stb && !ack && !err) ? m_wait + 1 : 0;
      end
    end
    chk("model_grant", 32'(O_grant), 32'(e.grant));
    chk("model_stb",   32'(S_STB_O), 32'(e.stb));
    chk("model_ack",   32'(M_ACK_O), 32'(e.ack));
    chk("model_err",   32'(M_ERR_O), 32'(e.err));
    chk("model_mdat",  32'(M_DAT_O), 32'(e.mdat));
    chk("model_adr",   S_ADR_O,      e.adr);
    chk("model_sdat",  32'(S_DAT_O), 32'(e.sdat));
    chk("model_we",    32'(S_WE_O),  32'(e.we));
  endtask

  // Model evaluates combinational expectations mid-cycle.
  always @(negedge clk) model_step();

  // Model state advances on the clock; reset acts immediately.
  always @(posedge clk or posedge RST_I) begin
    if (RST_I) begin
      m_owner <= -1; m_last <= NM - 1; m_wait <= 0;
    end else begin
      m_owner <= n_owner; m_last <= n_last; m_wait <= n_wait;
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [7:0]  ack;
    int          slot;
    logic        exp_ack;
    logic [7:0]  byte_v;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] pool [8] = '{32'hFFFF_F804, 32'h0000_1000, 32'h2000_1234, 32'h2100_0000,
                            32'h10AB_CDEF, 32'h4000_0000, 32'h6000_0001, 32'hFFFF_F9F0};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{32'hFFFF_F804, 1'b0, 8'h04, 2, 1'b1, 8'h5A};
    tbl[1] = '{32'h0000_1000, 1'b1, 8'h80, 7, 1'b1, 8'hC3};
    tbl[2] = '{32'h2000_1234, 1'b0, 8'h08, 1, 1'b0, 8'h99};
    tbl[3] = '{32'h2100_0000, 1'b1, 8'h08, 3, 1'b1, 8'h3C};
    tbl[4] = '{32'h10AB_CDEF, 1'b0, 8'h01, 0, 1'b1, 8'h01};
    tbl[5] = '{32'h7FFF_FFFF, 1'b0, 8'h7F, 7, 1'b0, 8'hE7};
    tbl[6] = '{32'h4000_0000, 1'b1, 8'h10, 4, 1'b1, 8'hA5};
    tbl[7] = '{32'hFFFF_F9F0, 1'b0, 8'h80, 7, 1'b1, 8'h77};
    tbl[8] = '{32'h6000_0001, 1'b0, 8'h00, 6, 1'b0, 8'h66};
    tbl[9] = '{32'h5123_4567, 1'b1, 8'h20, 5, 1'b1, 8'h55};

    // Reset state
    @(negedge clk);
    chk("rst_grant", 32'(O_grant), 32'h0);
    chk("rst_stb",   32'(S_STB_O), 32'h0);
    chk("rst_ack",   32'(M_ACK_O), 32'h0);
    chk("rst_err",   32'(M_ERR_O), 32'h0);
    chk("rst_mdat",  32'(M_DAT_O), 32'h0);
    next_cycle();
    RST_I = 1'b0;

    // Round-robin: both request together, M0 first, then M1, then M0 again
    m_cyc = 2'b11;
    @(negedge clk); chk("arb_idle", 32'(O_grant), 32'h0);
    next_cycle();
    @(negedge clk); chk("arb_m0_first", 32'(O_grant), 32'h1);
    next_cycle(); m_cyc = 2'b10;
    @(negedge clk); chk("arb_m0_hold", 32'(O_grant), 32'h1);
    next_cycle();
    @(negedge clk); chk("arb_gap", 32'(O_grant), 32'h0);
    next_cycle();
    @(negedge clk); chk("arb_m1", 32'(O_grant), 32'h2);
    next_cycle(); m_cyc = 2'b01;
    @(negedge clk); chk("arb_m1_hold", 32'(O_grant), 32'h2);
    next_cycle(); m_cyc = 2'b11;
    @(negedge clk); chk("arb_gap2", 32'(O_grant), 32'h0);
    next_cycle(); m_cyc = 2'b01;
    @(negedge clk); chk("arb_m0_again", 32'(O_grant), 32'h1);
    next_cycle();

    // Decode / data-path table, M0 owning the bus
    m_stb = 2'b01;
    for (int i = 0; i < 10; i++) begin
      m_adr[31:0] = tbl[i].adr;
      m_we[0]     = tbl[i].we;
      m_dat[7:0]  = 8'($urandom);
      s_ack       = tbl[i].ack;
      s_dat       = {$urandom, $urandom};
      s_dat[8*tbl[i].slot +: 8] = tbl[i].byte_v;
      @(negedge clk);
      chk("tbl_stb",  32'(S_STB_O), 32'h1 << tbl[i].slot);
      chk("tbl_adr",  S_ADR_O,      tbl[i].adr);
      chk("tbl_we",   32'(S_WE_O),  32'(tbl[i].we));
      chk("tbl_sdat", 32'(S_DAT_O), 32'(m_dat[7:0]));
      chk("tbl_ack",  32'(M_ACK_O), 32'(tbl[i].exp_ack));
      if (tbl[i].exp_ack) chk("tbl_mdat", 32'(M_DAT_O), 32'(tbl[i].byte_v));
      next_cycle();
    end

    // Timeout: four silent wait cycles, then a single ERR pulse
    m_adr[31:0] = 32'h4000_0000; s_ack = '0; m_we[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("to_wait_err", 32'(M_ERR_O), 32'h0);
      chk("to_wait_stb", 32'(S_STB_O), 32'h10);
      next_cycle();
    end
    @(negedge clk);
    chk("to_err",  32'(M_ERR_O), 32'h1);
    chk("to_stb",  32'(S_STB_O), 32'h0);
    chk("to_mdat", 32'(M_DAT_O), 32'hFF);
    chk("to_ack",  32'(M_ACK_O), 32'h0);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("to_after_err", 32'(M_ERR_O), 32'h0);
      chk("to_after_stb", 32'(S_STB_O), 32'h10);
      next_cycle();
    end
    // ACK on exactly the limit cycle wins over ERR
    s_ack = 8'h10;
    @(negedge clk);
    chk("edge_ack", 32'(M_ACK_O), 32'h1);
    chk("edge_err", 32'(M_ERR_O), 32'h0);
    chk("edge_stb", 32'(S_STB_O), 32'h10);
    next_cycle();

    // Asynchronous reset in the middle of a wait
    s_ack = '0;
    next_cycle();
    @(negedge clk);
    #2 RST_I = 1'b1;
    #1;
    chk("arst_grant", 32'(O_grant), 32'h0);
    chk("arst_stb",   32'(S_STB_O), 32'h0);
    chk("arst_err",   32'(M_ERR_O), 32'h0);
    next_cycle();
    RST_I = 1'b0;
    @(negedge clk); chk("arst_idle", 32'(O_grant), 32'h0);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("arst_no_err", 32'(M_ERR_O), 32'h0);
      chk("arst_regrant", 32'(O_grant), 32'h1);
      next_cycle();
    end
    m_cyc = '0; m_stb = '0;
    next_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int mm = 0; mm < NM; mm++) begin
        if (m_cyc[mm]) begin
          if ($urandom_range(0, 7) == 0) m_cyc[mm] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          m_cyc[mm] = 1'b1;
        end
        m_stb[mm] = m_cyc[mm] & ($urandom_range(0, 3) != 0);
        m_we[mm]  = 1'($urandom_range(0, 1));
        m_adr[32*mm +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
        m_dat[8*mm +: 8]   = 8'($urandom);
      end
      s_ack = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h00;
      s_dat = {$urandom, $urandom};
      RST_I = ($urandom_range(0, 199) == 0);
      next_cycle();
    end
    RST_I = 1'b0;
    m_cyc = '0; m_stb = '0;
    next_cycle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
